// File: rtl/async_fifo_pkg.sv
// rtl/async_fifo_pkg.sv - shared async FIFO sizing defaults and Gray/binary helpers
package async_fifo_pkg;

    localparam int ADDRSIZE = 4;
    localparam int POPW     = 2;
    localparam int PTRW     = ADDRSIZE + 1;

    function automatic logic [PTRW-1:0] bin2gray(input logic [PTRW-1:0] b);
        return (b >> 1) ^ b;
    endfunction

    function automatic logic [PTRW-1:0] gray2bin(input logic [PTRW-1:0] g);
        logic [PTRW-1:0] b;
        b[PTRW-1] = g[PTRW-1];
        for (int i = PTRW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/rptr_empty_lvl_if.sv
// rtl/rptr_empty_lvl_if.sv - read-side pointer/flag bundle between consumer, synchronizer and pointer block
interface rptr_empty_lvl_if #(
    parameter int ADDRSIZE = async_fifo_pkg::ADDRSIZE,
    parameter int POPW     = async_fifo_pkg::POPW
);
    logic                rinc;
    logic [POPW-1:0]     rnum;
    logic [ADDRSIZE:0]   rae_thresh;
    logic                rerr_clr;
    logic [ADDRSIZE:0]   rq2_wptr;
    logic [POPW-1:0]     rgrant;
    logic [ADDRSIZE-1:0] raddr;
    logic [ADDRSIZE:0]   rptr;
    logic                rempty;
    logic                ralmost_empty;
    logic [ADDRSIZE:0]   rlevel;
    logic                rerr_under;

    modport master (
        output rinc, rnum, rae_thresh, rerr_clr, rq2_wptr,
        input  rgrant, raddr, rptr, rempty, ralmost_empty, rlevel, rerr_under
    );

    modport slave (
        input  rinc, rnum, rae_thresh, rerr_clr, rq2_wptr,
        output rgrant, raddr, rptr, rempty, ralmost_empty, rlevel, rerr_under
    );
endinterface

// File: rtl/gray2bin_comb.sv
// rtl/gray2bin_comb.sv - combinational Gray-to-binary converter (XOR prefix from the MSB)
module gray2bin_comb #(
    parameter int W = async_fifo_pkg::PTRW
) (
    input  logic [W-1:0] gray,
    output logic [W-1:0] bin
);

    for (genvar i = 0; i < W; i++) begin : g_bit
        assign bin[i] = ^gray[W-1:i];
    end

endmodule

// File: rtl/rptr_empty_lvl.sv
// rtl/rptr_empty_lvl.sv - read pointer with variable pop count, exact level and registered empty/almost-empty/underflow flags
module rptr_empty_lvl #(
    parameter int ADDRSIZE = async_fifo_pkg::ADDRSIZE,
    parameter int POPW     = async_fifo_pkg::POPW
) (
    input  logic            rclk,
    input  logic            rrst,
    rptr_empty_lvl_if.slave bus
);

    localparam int PW = ADDRSIZE + 1;
    localparam logic [PW-1:0] DEPTH = {1'b1, {ADDRSIZE{1'b0}}};

    logic [PW-1:0]   rbin;
    logic [PW-1:0]   rwbin;
    logic [PW-1:0]   lvl_now;
    logic [POPW-1:0] req;
    logic [PW-1:0]   req_ext;
    logic [POPW-1:0] grant;
    logic [PW-1:0]   rbinnext;
    logic [PW-1:0]   rgraynext;
    logic [PW-1:0]   lvl_next;
    logic            under;

    logic [PW-1:0]   rptr_q;
    logic            rempty_q;
    logic            ralmost_empty_q;
    logic [PW-1:0]   rlevel_q;
    logic            rerr_under_q;

    gray2bin_comb #(.W(PW)) u_wptr_g2b (
        .gray (bus.rq2_wptr),
        .bin  (rwbin)
    );

    assign lvl_now = rwbin - rbin;
    assign req     = bus.rinc ? bus.rnum : '0;
    assign req_ext = PW'(req);

    // Partial grant: when fewer words are visible than requested, hand out what is there.
    assign grant     = (req_ext <= lvl_now) ? req : lvl_now[POPW-1:0];
    assign under     = bus.rinc && (PW'(bus.rnum) > lvl_now);
    assign rbinnext  = rbin + PW'(grant);
    assign rgraynext = (rbinnext >> 1) ^ rbinnext;
    assign lvl_next  = rwbin - rbinnext;

    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            rbin            <= '0;
            rptr_q          <= '0;
            rempty_q        <= 1'b1;
            ralmost_empty_q <= 1'b1;
            rlevel_q        <= '0;
            rerr_under_q    <= 1'b0;
        end else begin
            rbin            <= rbinnext;
            rptr_q          <= rgraynext;
            rempty_q        <= (rgraynext == bus.rq2_wptr);
            rlevel_q        <= lvl_next;
            ralmost_empty_q <= (lvl_next <= bus.rae_thresh);
            // Set has priority over clear so a same-cycle underflow is never lost.
            if (under) begin
                rerr_under_q <= 1'b1;
            end else if (bus.rerr_clr) begin
                rerr_under_q <= 1'b0;
            end
        end
    end

    assign bus.rgrant        = grant;
    assign bus.raddr         = rbin[ADDRSIZE-1:0];
    assign bus.rptr          = rptr_q;
    assign bus.rempty        = rempty_q;
    assign bus.ralmost_empty = ralmost_empty_q;
    assign bus.rlevel        = rlevel_q;
    assign bus.rerr_under    = rerr_under_q;

    // More than DEPTH words visible means the synchronized write pointer is corrupt.
    a_level_legal : assert property (@(posedge rclk) disable iff (rrst) lvl_now <= DEPTH);

endmodule

// File: tb/tb_rptr_empty_lvl.sv
// tb/tb_rptr_empty_lvl.sv - directed scoreboard bench for rptr_empty_lvl
module tb_rptr_empty_lvl;
    import async_fifo_pkg::*;

    typedef struct {
        logic [4:0] rptr;
        logic [3:0] raddr;
        logic       rempty;
        logic       ralm;
        logic [4:0] rlevel;
        logic       rerr;
    } exp_t;

    logic rclk = 1'b0;
    logic rrst = 1'b0;
    int   checks = 0;
    int   errors = 0;
    logic [4:0] m_rbin = '0;
    logic       m_err  = 1'b0;
    exp_t sb[$];

    rptr_empty_lvl_if #(.ADDRSIZE(4), .POPW(2)) bus ();

    rptr_empty_lvl #(.ADDRSIZE(4), .POPW(2)) dut (
        .rclk (rclk),
        .rrst (rrst),
        .bus  (bus)
    );

    always #5 rclk = ~rclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_state();
        chk("rst_rempty", 32'(bus.rempty), 32'd1);
        chk("rst_ralmost", 32'(bus.ralmost_empty), 32'd1);
        chk("rst_rlevel", 32'(bus.rlevel), 32'd0);
        chk("rst_rptr", 32'(bus.rptr), 32'd0);
        chk("rst_raddr", 32'(bus.raddr), 32'd0);
        chk("rst_rerr", 32'(bus.rerr_under), 32'd0);
    endtask

    task automatic step(input logic inc, input logic [1:0] num, input logic [4:0] wbin,
                        input logic [4:0] thr, input logic clr);
        logic [4:0] lvl, req, g, nb, nl;
        exp_t e;
        @(negedge rclk);
        bus.rinc       = inc;
        bus.rnum       = num;
        bus.rq2_wptr   = bin2gray(wbin);
        bus.rae_thresh = thr;
        bus.rerr_clr   = clr;
        #1;
        lvl = wbin - m_rbin;
        req = inc ? {3'b000, num} : 5'd0;
        g   = (req < lvl) ? req : lvl;
        chk("rgrant", 32'(bus.rgrant), 32'(g));
        nb = m_rbin + g;
        nl = wbin - nb;
        e.rptr   = bin2gray(nb);
        e.raddr  = nb[3:0];
        e.rempty = (nb == wbin);
        e.ralm   = (nl <= thr);
        e.rlevel = nl;
        e.rerr   = (inc && ({3'b000, num} > lvl)) ? 1'b1 : (clr ? 1'b0 : m_err);
        sb.push_back(e);
        m_rbin = nb;
        m_err  = e.rerr;
        @(posedge rclk);
        #1;
        e = sb.pop_front();
        chk("rptr", 32'(bus.rptr), 32'(e.rptr));
        chk("raddr", 32'(bus.raddr), 32'(e.raddr));
        chk("rempty", 32'(bus.rempty), 32'(e.rempty));
        chk("ralmost_empty", 32'(bus.ralmost_empty), 32'(e.ralm));
        chk("rlevel", 32'(bus.rlevel), 32'(e.rlevel));
        chk("rerr_under", 32'(bus.rerr_under), 32'(e.rerr));
    endtask

    initial begin
        bus.rinc       = 1'b0;
        bus.rnum       = '0;
        bus.rq2_wptr   = '0;
        bus.rae_thresh = '0;
        bus.rerr_clr   = 1'b0;

        #2 rrst = 1'b1;
        #1 chk_reset_state();
        @(negedge rclk);
        rrst = 1'b0;

        // burst pop of 3 with 5 visible
        step(1'b1, 2'd3, 5'd5, 5'd1, 1'b0);
        // partial grant / underflow, then set-beats-clear, then clear
        step(1'b1, 2'd3, 5'd5, 5'd1, 1'b0);
        step(1'b1, 2'd1, 5'd5, 5'd1, 1'b1);
        step(1'b0, 2'd0, 5'd5, 5'd1, 1'b1);

        // walk the read pointer up to 30 with small pops
        for (int k = 0; k < 20 && m_rbin != 5'd30; k++) begin
            logic [4:0] n;
            n = (5'd30 - m_rbin > 5'd3) ? 5'd3 : 5'd30 - m_rbin;
            step(1'b1, n[1:0], m_rbin + 5'd4, 5'd1, 1'b0);
        end
        chk("walk_rbin", 32'(bus.raddr), 32'd14);

        // wrap 30 -> 1 with level 3
        step(1'b1, 2'd3, 5'd1, 5'd1, 1'b0);
        chk("wrap_rptr", 32'(bus.rptr), 32'b00001);

        // almost-empty threshold crossing
        step(1'b1, 2'd1, 5'd5, 5'd2, 1'b0);
        step(1'b1, 2'd1, 5'd5, 5'd2, 1'b0);

        // five pops then asynchronous mid-cycle reset
        for (int k = 0; k < 5; k++) begin
            step(1'b1, 2'd1, 5'd8, 5'd2, 1'b0);
        end
        #2;
        bus.rinc = 1'b0;
        rrst = 1'b1;
        #1 chk_reset_state();
        @(negedge rclk);
        rrst   = 1'b0;
        m_rbin = '0;
        m_err  = 1'b0;

        // full FIFO, zero-count pop, threshold change
        step(1'b1, 2'd3, 5'd16, 5'd2, 1'b0);
        step(1'b1, 2'd0, 5'd16, 5'd2, 1'b0);
        step(1'b0, 2'd3, 5'd16, 5'd15, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
